// File: rtl/crc16_pkg.sv
// CRC-16/ANSI shared definitions: polynomial, init value, types and single-bit LFSR step.
// Used by the serial core and the frame controller. The bench can use it too.
// No ports. Package only.
package crc16_pkg;

  localparam logic [15:0] CRC16_ANSI_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT      = 16'h0000;

  typedef logic [15:0] crc16_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Advance the MSB-first, non-reflected LFSR by one message bit.
  function automatic crc16_t crc16_step(crc16_t crc, logic b,
                                        crc16_t poly = CRC16_ANSI_POLY);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_frame_ctrl_if.sv
// Byte-input and CRC-result handshake bundle for crc16_frame_ctrl.
// slave: the controller (accepts bytes, produces the result).
// master: the packet source / result consumer side.
interface crc16_frame_ctrl_if;
  import crc16_pkg::*;

  logic [7:0] s_data_i;
  logic       s_valid_i;
  logic       s_last_i;
  logic       s_ready_o;
  crc16_t     m_crc_o;
  logic       m_valid_o;
  logic       m_ready_i;

  modport slave (
    input  s_data_i, s_valid_i, s_last_i, m_ready_i,
    output s_ready_o, m_crc_o, m_valid_o
  );

  modport master (
    output s_data_i, s_valid_i, s_last_i, m_ready_i,
    input  s_ready_o, m_crc_o, m_valid_o
  );

endinterface

// File: rtl/crc16_serial_core.sv
// Bit-serial CRC-16 LFSR: one message bit per clock when en_i, synchronous clear to INIT.
// Ports: clk_i, rst_i (async active-low), en_i (advance), clr_i (load INIT, wins over en_i),
//        data_i (message bit), crc_o (current LFSR contents).
module crc16_serial_core
  import crc16_pkg::*;
#(
  parameter crc16_t POLY = CRC16_ANSI_POLY,
  parameter crc16_t INIT = CRC16_INIT
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   en_i,
  input  logic   clr_i,
  input  logic   data_i,
  output crc16_t crc_o
);

  crc16_t crc_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      crc_q <= INIT;
    end else if (clr_i) begin
      crc_q <= INIT;
    end else if (en_i) begin
      crc_q <= crc16_step(crc_q, data_i, POLY);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/crc16_frame_ctrl.sv
// Byte-stream sequencer for the serial CRC-16: serialises bytes MSB-first, one bit per clock,
// 8 cycles per byte (full throughput when s_valid_i is held), result valid 8 cycles after the last byte.
// Ports: clk_i, rst_i (async active-low), bus (slave modport: byte in / CRC out), busy_o.
// Backpressure: s_ready_o only in IDLE or on the final bit of a non-last byte; DONE holds until m_ready_i.
module crc16_frame_ctrl
  import crc16_pkg::*;
#(
  parameter crc16_t POLY = CRC16_ANSI_POLY,
  parameter crc16_t INIT = CRC16_INIT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  crc16_frame_ctrl_if.slave  bus,
  output logic               busy_o
);

  state_e     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] cnt_q,   cnt_d;
  logic       last_q,  last_d;
  logic       first_q, first_d;
  logic       busy_q,  busy_d;
  crc16_t     res_q,   res_d;   // last delivered CRC, shown on m_crc_o outside DONE

  logic   s_ready;
  logic   s_accept;
  logic   core_en;
  logic   core_clr;
  crc16_t core_crc;

  crc16_serial_core #(
    .POLY (POLY),
    .INIT (INIT)
  ) u_core (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (core_en),
    .clr_i  (core_clr),
    .data_i (shreg_q[7]),
    .crc_o  (core_crc)
  );

  // Ready depends only on state and counter, never on s_valid_i.
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      IDLE:    s_ready = 1'b1;
      SHIFT:   s_ready = (cnt_q == 3'd0) && !last_q;
      default: s_ready = 1'b0;
    endcase
  end

  assign s_accept = bus.s_valid_i & s_ready;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    first_d  = first_q;
    busy_d   = busy_q;
    res_d    = res_q;
    core_en  = 1'b0;
    core_clr = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_accept) begin
          shreg_d = bus.s_data_i;
          last_d  = bus.s_last_i;
          if (first_q) begin
            core_clr = 1'b1;
            first_d  = 1'b0;
          end
          busy_d  = 1'b1;
          cnt_d   = 3'd7;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        core_en = 1'b1;
        shreg_d = {shreg_q[6:0], 1'b0};
        cnt_d   = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          if (last_q) begin
            state_d = DONE;
          end else if (s_accept) begin
            // Next byte loads on the same edge the final bit shifts: no bubble.
            shreg_d = bus.s_data_i;
            last_d  = bus.s_last_i;
            cnt_d   = 3'd7;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DONE: begin
        if (bus.m_ready_i) begin
          res_d   = core_crc;
          first_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      shreg_q <= 8'h00;
      cnt_q   <= 3'd0;
      last_q  <= 1'b0;
      first_q <= 1'b1;
      busy_q  <= 1'b0;
      res_q   <= INIT;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      res_q   <= res_d;
    end
  end

  assign bus.s_ready_o = s_ready;
  assign bus.m_valid_o = (state_q == DONE);
  assign bus.m_crc_o   = (state_q == DONE) ? core_crc : res_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// Self-checking bench for crc16_frame_ctrl: vector table of single-byte frames, hand sequences
// (streaming, gaps, back-pressure, mid-frame reset) and random frames against a long-division model.
// No ports.
module tb_crc16_frame_ctrl;
  import crc16_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [7:0] data;
    crc16_t     exp_crc;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   since = 100;
  bit   mon_en = 1'b0;

  crc16_frame_ctrl_if bus();

  crc16_frame_ctrl dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .bus    (bus),
    .busy_o (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // CRC as remainder of the augmented message M(x)*x^16 divided by x^16+x^15+x^2+1 (init 0).
  function automatic crc16_t model_crc(input byte_q_t msg);
    logic [16:0] r;
    r = 17'h0;
    for (int i = 0; i < msg.size(); i++)
      for (int k = 7; k >= 0; k--) begin
        r = {r[15:0], msg[i][k]};
        if (r[16]) r = r ^ 17'h18005;
      end
    for (int k = 0; k < 16; k++) begin
      r = {r[15:0], 1'b0};
      if (r[16]) r = r ^ 17'h18005;
    end
    return r[15:0];
  endfunction

  // Ready must stay low for the 7 cycles following every accepted byte.
  always @(negedge clk) begin
    #2;
    if (mon_en && rst_n) begin
      if (since < 7) check("sready_mid_byte", 32'(bus.s_ready_o), 32'd0);
      if (bus.s_valid_i && bus.s_ready_o) since = 0;
      else if (since < 100) since++;
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic l, input int gap, output int acc);
    int t;
    bus.s_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
    bus.s_data_i  = d;
    bus.s_last_i  = l;
    bus.s_valid_i = 1'b1;
    t = 0;
    while (!bus.s_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: s_ready_o stayed 0, required 1");
      bus.s_valid_i = 1'b0;
      acc = -1;
      return;
    end
    @(negedge clk);
    acc = cyc;
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = 8'($urandom);
    bus.s_last_i  = 1'($urandom);
  endtask

  task automatic wait_result(output crc16_t crc, output int vc);
    int t;
    t = 0;
    while (!bus.m_valid_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      tests++;
      fails++;
      $display("FAIL result_timeout: m_valid_o stayed 0, required 1");
    end
    vc  = cyc;
    crc = bus.m_crc_o;
  endtask

  task automatic take_result();
    bus.m_ready_i = 1'b1;
    @(negedge clk);
    bus.m_ready_i = 1'b0;
    check("valid_after_take", 32'(bus.m_valid_o), 32'd0);
    check("busy_after_take", 32'(busy), 32'd0);
  endtask

  task automatic send_frame(input byte_q_t msg, input int maxgap,
                            output crc16_t crc, output int first_acc, output int last_acc,
                            output int vc);
    int acc;
    first_acc = -1;
    last_acc  = -1;
    for (int i = 0; i < msg.size(); i++) begin
      send_byte(msg[i], (i == msg.size() - 1), (maxgap == 0) ? 0 : $urandom_range(0, maxgap), acc);
      if (i == 0) first_acc = acc;
      last_acc = acc;
    end
    wait_result(crc, vc);
  endtask

  initial begin
    vec_t    vecs[4];
    byte_q_t msg;
    byte_q_t one;
    crc16_t  crc, exp;
    int      acc, prev_acc, fa, la, vc;

    bus.s_data_i  = 8'h00;
    bus.s_valid_i = 1'b0;
    bus.s_last_i  = 1'b0;
    bus.m_ready_i = 1'b0;

    vecs[0] = '{8'h01, 16'h8005};
    vecs[1] = '{8'h00, 16'h0000};
    vecs[2] = '{8'h80, 16'h8303};
    one = {8'hFF};
    vecs[3] = '{8'hFF, model_crc(one)};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(bus.s_ready_o), 32'd1);
    check("rst_m_valid", 32'(bus.m_valid_o), 32'd0);
    check("rst_m_crc", 32'(bus.m_crc_o), 32'(CRC16_INIT));
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-byte frames from the table
    foreach (vecs[i]) begin
      send_byte(vecs[i].data, 1'b1, 0, acc);
      check("single_busy", 32'(busy), 32'd1);
      wait_result(crc, vc);
      check("single_crc", 32'(crc), 32'(vecs[i].exp_crc));
      check("single_latency", 32'(vc - acc), 32'd8);
      take_result();
    end

    // "123456789" with valid held high
    msg = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    mon_en = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < msg.size(); i++) begin
      send_byte(msg[i], (i == msg.size() - 1), 0, acc);
      if (i == 0) fa = acc;
      else check("stream_interval", 32'(acc - prev_acc), 32'd8);
      prev_acc = acc;
    end
    wait_result(crc, vc);
    check("stream_crc", 32'(crc), 32'hFEE8);
    check("stream_total", 32'(vc - fa), 32'd72);
    take_result();

    // Same frame with random idle gaps
    send_frame(msg, 5, crc, fa, la, vc);
    check("gap_crc", 32'(crc), 32'hFEE8);
    check("gap_latency", 32'(vc - la), 32'd8);
    take_result();
    mon_en = 1'b0;

    // Back-pressure in DONE; m_crc_o holds the previous result while the next frame runs
    msg = {8'h31, 8'h32};
    exp = model_crc(msg);
    send_byte(msg[0], 1'b0, 0, acc);
    check("hold_prev_result", 32'(bus.m_crc_o), 32'hFEE8);
    send_byte(msg[1], 1'b1, 0, acc);
    wait_result(crc, vc);
    check("bp_crc", 32'(crc), 32'(exp));
    for (int i = 0; i < 20; i++) begin
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = 8'($urandom);
      bus.s_last_i  = 1'($urandom);
      @(negedge clk);
      check("bp_valid", 32'(bus.m_valid_o), 32'd1);
      check("bp_crc_stable", 32'(bus.m_crc_o), 32'(exp));
      check("bp_s_ready", 32'(bus.s_ready_o), 32'd0);
    end
    bus.m_ready_i = 1'b1;
    @(negedge clk);
    bus.m_ready_i = 1'b0;
    bus.s_valid_i = 1'b0;
    check("bp_take_valid", 32'(bus.m_valid_o), 32'd0);
    check("bp_take_busy", 32'(busy), 32'd0);
    check("bp_take_s_ready", 32'(bus.s_ready_o), 32'd1);
    check("bp_crc_held", 32'(bus.m_crc_o), 32'(exp));
    one = {8'h01};
    send_frame(one, 0, crc, fa, la, vc);
    check("bp_reinit_crc", 32'(crc), 32'h8005);
    take_result();

    // Reset during the second byte of a frame
    send_byte(8'h31, 1'b0, 0, acc);
    send_byte(8'h32, 1'b0, 0, acc);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_s_ready", 32'(bus.s_ready_o), 32'd1);
    check("midrst_m_valid", 32'(bus.m_valid_o), 32'd0);
    check("midrst_m_crc", 32'(bus.m_crc_o), 32'(CRC16_INIT));
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(one, 0, crc, fa, la, vc);
    check("midrst_next_crc", 32'(crc), 32'h8005);
    check("midrst_latency", 32'(vc - la), 32'd8);
    take_result();

    // Random frames against the model
    for (int f = 0; f < 20; f++) begin
      int len;
      len = $urandom_range(1, 6);
      msg = {};
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      exp = model_crc(msg);
      send_frame(msg, 3, crc, fa, la, vc);
      check("rand_crc", 32'(crc), 32'(exp));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("rand_crc_stable", 32'(bus.m_crc_o), 32'(exp));
      take_result();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/crc16_frame_ctrl.md
Name: crc16_frame_ctrl

Overview:
Byte-stream front end and sequencer for the serial CRC-16/ANSI LFSR (poly 0x8005, MSB-first, no reflection, no xorout).
- Accepts bytes on a valid/ready interface and serialises each byte MSB-first into the LFSR, one bit per clock.
- Clears the LFSR at frame start.
- Presents the final 16-bit CRC on a valid/ready result port when the byte flagged last has been shifted.
- Sits between a packet source and the framer that appends or checks the FCS.

Parameters:
POLY, 16'h8005, generator polynomial (implicit x^16 term)
INIT, 16'h0000, LFSR value loaded at the first byte of each frame

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_i  input  1  reset, asynchronous assert, active-low (0 = reset)
s_data_i  input  8  input byte
s_valid_i  input  1  byte valid
s_last_i  input  1  byte is the final byte of the frame; qualified by s_valid_i
s_ready_o  output  1  controller can accept a byte this cycle
m_crc_o  output  16  frame CRC; stable while m_valid_o=1
m_valid_o  output  1  CRC result valid
m_ready_i  input  1  result consumer ready
busy_o  output  1  frame in progress (first byte accepted, result not yet taken)

Behaviour:
- Reset (rst_i=0, asynchronous, any state): FSM=IDLE, LFSR=INIT, bit counter=0, first-byte flag=1. Outputs: s_ready_o=1, m_valid_o=0, m_crc_o=INIT, busy_o=0. Reset mid-frame discards the partial frame; no result is produced for it.
- Handshakes:
  - Input transfer occurs on a rising edge with s_valid_i & s_ready_o.
  - Result transfer occurs with m_valid_o & m_ready_i.
  - s_ready_o is combinational from state/counter only, never from s_valid_i.
- LFSR step per bit b: fb = crc[15]^b; crc <= {crc[14:0],1'b0} ^ (fb ? POLY : 0).
- States:
  - IDLE: s_ready_o=1. On accept: latch byte into 8-bit shift register; latch last flag; if first-byte flag=1, LFSR<=INIT and clear the flag; busy_o<=1; counter<=7; go SHIFT.
  - SHIFT: feed shift_reg[7] to the LFSR, shift the register left, decrement the counter. s_ready_o=1 only when counter==0 and the latched last flag=0.
    - On the counter==0 edge with last=0 and an accept: load the next byte, counter<=7, stay SHIFT. This gives full throughput of 8 cycles per byte.
    - On the counter==0 edge with last=0 and no accept: go IDLE.
    - On the counter==0 edge with last=1: go DONE.
  - DONE: m_valid_o=1, m_crc_o=LFSR, s_ready_o=0, LFSR frozen. On m_ready_i=1: m_valid_o<=0, first-byte flag<=1, busy_o<=0, go IDLE. A new byte is never accepted in the same cycle the result is taken.
- Latency: byte accepted at edge E0; its 8 bits shift at E1..E8. For a last byte, m_valid_o is high after E8, i.e. 8 cycles after acceptance.
- m_crc_o holds the last result (or INIT after reset) outside DONE. Only m_valid_o qualifies it.
- s_data_i and s_last_i are ignored when s_valid_i=0 or s_ready_o=0.
- Single-byte frames are legal: accept the byte with s_last_i=1 while in IDLE.
- Back-pressure: m_ready_i held low keeps DONE indefinitely with m_crc_o stable; s_ready_o stays 0.
- Empty frames are not supported. A frame begins only with a byte.

Decomposition:
- Package crc16_pkg holds:
  - CRC16_ANSI_POLY = 16'h8005 and CRC16_INIT = 16'h0000
  - typedef crc16_t (logic [15:0])
  - state enum {IDLE, SHIFT, DONE}
  - function crc16_step(crc16_t crc, logic bit) for shared use by RTL and bench model
- One sub-module: crc16_serial_core. Ports: clk_i, rst_i (active-low async), en_i, clr_i, data_i, crc_o. It is the bit-serial LFSR with synchronous clear to INIT and advance on en_i.
- The controller owns the FSM, the byte shift register and the bit counter.

Test Plan:
- Reset mid-frame: assert rst_i=0 during SHIFT of the 2nd byte, release, then send single byte 0x01 last -> outputs return to reset values immediately; the next result is 0x8005, unaffected by the aborted frame.
- Single byte 0x01 last -> m_crc_o=16'h8005, m_valid_o rises exactly 8 cycles after acceptance; single byte 0x00 -> 16'h0000.
- Single byte 0x80 last -> m_crc_o=16'h8303.
- ASCII "123456789" streamed with s_valid_i held high, last on '9' -> m_crc_o=16'hFEE8; s_ready_o pulses every 8 cycles; total 72 cycles from first accept to m_valid_o.
- Same frame with random s_valid_i gaps (0-5 idle cycles per byte) -> m_crc_o=16'hFEE8; s_ready_o never high during non-final SHIFT cycles.
- Back-pressure: hold m_ready_i=0 for 20 cycles in DONE -> m_valid_o and m_crc_o stable, s_ready_o=0, s_valid_i ignored. Release, then send 0x01 -> 16'h8005, proving the LFSR reinitialised to INIT.
